// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone classic initiator.
// Optional timeout logic is enabled with WB_INITIATOR_TIMEOUT_EN.
package wb_initiator_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Cycle counter that flags expiry on the LIMIT-th enabled cycle.
// Used by wb_initiator only when WB_INITIATOR_TIMEOUT_EN is defined.
module wb_timeout_cnt
  import wb_initiator_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count holds LIMIT-1 during the LIMIT-th enabled cycle
  assign expired_o = enable_i && (cnt_q == 16'(LIMIT - 1));

endmodule

// File: rtl/wb_initiator.sv
// Single-transfer Wishbone classic initiator with command/response handshakes.
// Define WB_INITIATOR_TIMEOUT_EN to abort silent transfers after TIMEOUT_CYC.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [WB_AW-1:0] cmd_adr_i,
  input  logic [WB_DW-1:0] cmd_dat_i,
  input  logic [WB_SW-1:0] cmd_sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WB_DW-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  output logic             rsp_timeout_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  input  logic [WB_DW-1:0] wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  output logic             busy_o
);

  wb_state_e        state_q, state_d;
  logic             we_q, we_d;
  logic [WB_SW-1:0] sel_q, sel_d;
  logic [WB_AW-1:0] adr_q, adr_d;
  logic [WB_DW-1:0] dat_q, dat_d;
  logic [WB_DW-1:0] rdat_q, rdat_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic             accept;
  logic             in_req;
  logic             expired;

  assign accept = (state_q == ST_IDLE) && cmd_valid_i;
  assign in_req = (state_q == ST_REQ);

`ifdef WB_INITIATOR_TIMEOUT_EN
  wb_timeout_cnt #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_n_i),
    .clear_i  (accept),
    .enable_i (in_req),
    .expired_o(expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign expired = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid_i) state_d = ST_REQ;
      ST_REQ: begin
        if (wbm_err_i || wbm_ack_i || expired) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_d   = we_q;
    sel_d  = sel_q;
    adr_d  = adr_q;
    dat_d  = dat_q;
    rdat_d = rdat_q;
    err_d  = err_q;
    to_d   = to_q;
    if (accept) begin
      we_d  = cmd_we_i;
      sel_d = cmd_sel_i;
      adr_d = cmd_adr_i;
      dat_d = cmd_dat_i;
    end
    // Bus error beats ack; both beat a coincident timeout
    if (in_req) begin
      priority case (1'b1)
        wbm_err_i: begin
          rdat_d = '0;
          err_d  = 1'b1;
          to_d   = 1'b0;
        end
        wbm_ack_i: begin
          rdat_d = we_q ? '0 : wbm_dat_i;
          err_d  = 1'b0;
          to_d   = 1'b0;
        end
        expired: begin
          rdat_d = '0;
          err_d  = 1'b1;
          to_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      we_q   <= 1'b0;
      sel_q  <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      rdat_q <= '0;
      err_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      we_q   <= we_d;
      sel_q  <= sel_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      rdat_q <= rdat_d;
      err_q  <= err_d;
      to_q   <= to_d;
    end
  end

  always_comb begin
    cmd_ready_o   = (state_q == ST_IDLE);
    rsp_valid_o   = (state_q == ST_RESP);
    busy_o        = (state_q != ST_IDLE);
    wbm_cyc_o     = in_req;
    wbm_stb_o     = in_req;
    wbm_we_o      = we_q;
    wbm_sel_o     = sel_q;
    wbm_adr_o     = adr_q;
    wbm_dat_o     = dat_q;
    rsp_dat_o     = rdat_q;
    rsp_err_o     = err_q;
    rsp_timeout_o = to_q;
  end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the number of REQ-state cycles without ack/err before abort (range 1..65535).
REQ-002 wb_clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 wb_rst_n_i  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 cmd_valid_i / cmd_ready_o  in/out  1/1  SHALL form the command handshake; transfer when both are high at a rising edge.
REQ-005 cmd_we_i  input  1; cmd_adr_i  input  32; cmd_dat_i  input  32; cmd_sel_i  input  4  SHALL carry write-enable, address, write data and byte selects.
REQ-006 rsp_valid_o / rsp_ready_i  out/in  1/1  SHALL form the response handshake.
REQ-007 rsp_dat_o  output  32; rsp_err_o  output  1; rsp_timeout_o  output  1  SHALL carry read data, error flag and timeout flag.
REQ-008 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1; wbm_sel_o  output  4; wbm_adr_o  output  32; wbm_dat_o  output  32  SHALL be the Wishbone classic initiator outputs.
REQ-009 wbm_dat_i  input  32; wbm_ack_i  input  1; wbm_err_i  input  1  SHALL be the Wishbone responder returns.
REQ-010 busy_o  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-011 FSM states SHALL be IDLE, REQ, RESP.
REQ-012 cmd_ready_o SHALL equal (state==IDLE); commands SHALL be accepted only in IDLE.
REQ-013 On command accept, block SHALL register we/adr/dat/sel, move to REQ, and drive wbm_cyc_o=wbm_stb_o=1 from the next cycle.
REQ-014 In REQ, wbm_we_o/sel_o/adr_o/dat_o SHALL hold the registered values unchanged.
REQ-015 In REQ, on a cycle with wbm_ack_i=1, block SHALL capture wbm_dat_i (reads) or 0 (writes) into rsp_dat_o, set rsp_err_o=0, drop cyc/stb at that edge, enter RESP.
REQ-016 In REQ, wbm_err_i=1 SHALL produce rsp_err_o=1, rsp_dat_o=0, drop cyc/stb, enter RESP; err SHALL take priority over simultaneous ack.
REQ-017 ack/err outside REQ SHALL be ignored.
REQ-018 rsp_valid_o SHALL equal (state==RESP); rsp_* SHALL stay stable until rsp_ready_i=1, then FSM SHALL return to IDLE.
REQ-019 Minimum latency SHALL be: accept edge N, cyc/stb high cycle N+1, ack in N+1 gives rsp_valid_o high in cycle N+2; with rsp_ready_i high, cmd_ready_o high in N+3.
REQ-020 wbm_stb_o SHALL never be high with wbm_cyc_o low; exactly one stb phase per command.

Reset
REQ-021 Asserting wb_rst_n_i low SHALL immediately force IDLE, cyc/stb/we=0, sel/adr/dat outputs=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, rsp_timeout_o=0, busy_o=0, timeout counter=0.
REQ-022 Reset mid-transaction SHALL drop cyc/stb asynchronously and discard the pending response.

Configuration
REQ-023 Macro WB_INITIATOR_TIMEOUT_EN defined: a counter SHALL clear on entering REQ, increment each REQ cycle, and on reaching TIMEOUT_CYC without ack/err SHALL drop cyc/stb, set rsp_err_o=1, rsp_timeout_o=1, rsp_dat_o=0, enter RESP.
REQ-024 Macro undefined: no counter logic, REQ SHALL wait indefinitely, rsp_timeout_o SHALL be tied 0.
REQ-025 ack/err arriving on the same cycle the count reaches TIMEOUT_CYC SHALL win over timeout.

Structure
REQ-026 Package wb_initiator_pkg SHALL hold the state enum type, WB data/address/sel width constants, and default TIMEOUT_CYC.
REQ-027 Timeout counter SHALL be sub-module wb_timeout_cnt (inputs clear, enable; output expired), instantiated only under WB_INITIATOR_TIMEOUT_EN.

Verification
REQ-028 Write adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, responder acks after 2 wait cycles -> wbm bus shows those values for 3 cycles, rsp_err=0, rsp_dat=0.
REQ-029 Read adr=0x3000_0000, responder acks 1st cycle with 0x1234_5678 -> rsp_dat=0x1234_5678 at cycle N+2, rsp_err=0.
REQ-030 Read with ack and err both high same cycle -> rsp_err=1, rsp_dat=0.
REQ-031 Timeout build, TIMEOUT_CYC=8, silent responder -> cyc drops after 8 REQ cycles, rsp_err=1, rsp_timeout=1; non-timeout build -> cyc stays high 100 cycles.
REQ-032 Reset low during REQ, then rsp_ready held low 5 cycles on a later response -> cyc/stb drop immediately, rsp_valid=0 after reset; later rsp_dat stable all 5 cycles, cmd_ready=0 until handshake.
